// File: rtl/wb_burst_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | wb_burst_master                                                          |
// | Wishbone B3 initiator: turns a command/stream port into linear bursts.   |
// | Optional macro WB_BURST_MASTER_RTY_EN: resume after wbm_rty_i instead of |
// | aborting.                                                                |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module wb_burst_master #(
  parameter int dw = 32,
  parameter int aw = 32,
  parameter int lw = 8
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic          cmd_we_i,
  input  logic [aw-1:0] cmd_adr_i,
  input  logic [lw-1:0] cmd_len_i,
  input  logic [dw-1:0] wdat_i,
  input  logic          wdat_valid_i,
  output logic          wdat_ready_o,
  output logic [dw-1:0] rdat_o,
  output logic          rdat_valid_o,
  output logic          done_o,
  output logic          err_o,
  output logic [aw-1:0] wbm_adr_o,
  output logic [1:0]    wbm_bte_o,
  output logic [2:0]    wbm_cti_o,
  output logic          wbm_cyc_o,
  output logic          wbm_stb_o,
  output logic          wbm_we_o,
  output logic [3:0]    wbm_sel_o,
  output logic [dw-1:0] wbm_dat_o,
  input  logic          wbm_ack_i,
  input  logic          wbm_err_i,
  input  logic          wbm_rty_i,
  input  logic [dw-1:0] wbm_dat_i
);

  localparam logic [1:0] c_idle  = 2'd0;
  localparam logic [1:0] c_bus   = 2'd1;
  localparam logic [1:0] c_retry = 2'd2;

  logic [1:0]    r_state;
  logic [1:0]    w_next_state;
  logic          r_we;
  logic [aw-1:0] r_adr;
  logic [lw-1:0] r_rem;
  logic [dw-1:0] r_rdat;
  logic          r_rdat_valid;
  logic          r_done;
  logic          r_err;

  logic w_in_bus;
  logic w_stb;
  logic w_abort;
  logic w_retry;
  logic w_beat_ack;
  logic w_last;

  assign w_in_bus = (r_state == c_bus);
  assign w_last   = (r_rem == '0);
  // Writes only strobe while the stream has data; otherwise cyc is held as a wait state.
  assign w_stb    = w_in_bus & (r_we ? wdat_valid_i : 1'b1);

`ifdef WB_BURST_MASTER_RTY_EN
  assign w_abort = w_in_bus & wbm_err_i;
  assign w_retry = w_in_bus & wbm_rty_i & ~wbm_err_i;
`else
  assign w_abort = w_in_bus & (wbm_err_i | wbm_rty_i);
  assign w_retry = 1'b0;
`endif

  // A terminating err or rty takes priority over an ack in the same cycle.
  assign w_beat_ack = w_stb & wbm_ack_i & ~w_abort & ~w_retry;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_idle: begin
        if (cmd_valid_i) begin
          w_next_state = c_bus;
        end
      end
      c_bus: begin
        if (w_abort) begin
          w_next_state = c_idle;
        end else if (w_retry) begin
          w_next_state = c_retry;
        end else if (w_beat_ack && w_last) begin
          w_next_state = c_idle;
        end
      end
      c_retry: begin
        w_next_state = c_bus;
      end
      default: begin
        w_next_state = c_idle;
      end
    endcase
  end

  always_comb begin
    cmd_ready_o  = (r_state == c_idle);
    wbm_cyc_o    = w_in_bus;
    wbm_stb_o    = w_stb;
    wbm_we_o     = w_in_bus & r_we;
    wbm_sel_o    = w_in_bus ? 4'hf : 4'h0;
    wbm_bte_o    = 2'b00;
    wbm_cti_o    = w_in_bus ? (w_last ? 3'b111 : 3'b010) : 3'b000;
    wbm_adr_o    = r_adr;
    wbm_dat_o    = wdat_i;
    wdat_ready_o = w_beat_ack & r_we;
    rdat_o       = r_rdat;
    rdat_valid_o = r_rdat_valid;
    done_o       = r_done;
    err_o        = r_err;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_we         <= 1'b0;
      r_adr        <= '0;
      r_rem        <= '0;
      r_rdat       <= '0;
      r_rdat_valid <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_rdat_valid <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      if ((r_state == c_idle) && cmd_valid_i) begin
        r_we  <= cmd_we_i;
        r_adr <= cmd_adr_i;
        r_rem <= cmd_len_i;
      end
      if (w_abort) begin
        r_done <= 1'b1;
        r_err  <= 1'b1;
      end
      if (w_beat_ack) begin
        r_adr <= r_adr + aw'(4);
        if (w_last) begin
          r_done <= 1'b1;
        end else begin
          r_rem <= r_rem - lw'(1);
        end
        if (!r_we) begin
          r_rdat       <= wbm_dat_i;
          r_rdat_valid <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_burst_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_wb_burst_master                                                       |
// | Randomized bench with a beat-level slave/reference model.                |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_wb_burst_master;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic        cmd_valid_i, cmd_ready_o, cmd_we_i;
  logic [31:0] cmd_adr_i;
  logic [7:0]  cmd_len_i;
  logic [31:0] wdat_i;
  logic        wdat_valid_i, wdat_ready_o;
  logic [31:0] rdat_o;
  logic        rdat_valid_o, done_o, err_o;
  logic [31:0] wbm_adr_o;
  logic [1:0]  wbm_bte_o;
  logic [2:0]  wbm_cti_o;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_dat_o;
  logic        wbm_ack_i, wbm_err_i, wbm_rty_i;
  logic [31:0] wbm_dat_i;

  int checks   = 0;
  int failures = 0;

  logic [31:0] wq [256];

  always #5 wb_clk_i = ~wb_clk_i;

  wb_burst_master dut (
    .wb_clk_i     (wb_clk_i),
    .wb_rst_i     (wb_rst_i),
    .cmd_valid_i  (cmd_valid_i),
    .cmd_ready_o  (cmd_ready_o),
    .cmd_we_i     (cmd_we_i),
    .cmd_adr_i    (cmd_adr_i),
    .cmd_len_i    (cmd_len_i),
    .wdat_i       (wdat_i),
    .wdat_valid_i (wdat_valid_i),
    .wdat_ready_o (wdat_ready_o),
    .rdat_o       (rdat_o),
    .rdat_valid_o (rdat_valid_o),
    .done_o       (done_o),
    .err_o        (err_o),
    .wbm_adr_o    (wbm_adr_o),
    .wbm_bte_o    (wbm_bte_o),
    .wbm_cti_o    (wbm_cti_o),
    .wbm_cyc_o    (wbm_cyc_o),
    .wbm_stb_o    (wbm_stb_o),
    .wbm_we_o     (wbm_we_o),
    .wbm_sel_o    (wbm_sel_o),
    .wbm_dat_o    (wbm_dat_o),
    .wbm_ack_i    (wbm_ack_i),
    .wbm_err_i    (wbm_err_i),
    .wbm_rty_i    (wbm_rty_i),
    .wbm_dat_i    (wbm_dat_i)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_cyc"},   32'(wbm_cyc_o), 0);
    check_eq({tag, "_stb"},   32'(wbm_stb_o), 0);
    check_eq({tag, "_we"},    32'(wbm_we_o), 0);
    check_eq({tag, "_adr"},   wbm_adr_o, 0);
    check_eq({tag, "_cti"},   32'(wbm_cti_o), 0);
    check_eq({tag, "_bte"},   32'(wbm_bte_o), 0);
    check_eq({tag, "_rv"},    32'(rdat_valid_o), 0);
    check_eq({tag, "_rdat"},  rdat_o, 0);
    check_eq({tag, "_done"},  32'(done_o), 0);
    check_eq({tag, "_err"},   32'(err_o), 0);
    check_eq({tag, "_ready"}, 32'(cmd_ready_o), 1);
  endtask

  // Called just after a falling edge. Beat indices are 0-based; -1 disables an event.
  task automatic run_cmd(input logic we, input logic [31:0] adr, input int len, input int ackp,
                         input int stall, input int err_beat, input int rty_beat, input int rst_beat);
    int          beat, cyc_n, stall_left, nbeats;
    logic        exp_rv, exp_done, exp_err, retry_pend, rst_pend, finished, ev_used;
    logic [31:0] exp_rdat, ea;
    nbeats = len + 1;
    for (int i = 0; i < 256; i++) wq[i] = $urandom;
    cmd_valid_i = 1'b1;
    cmd_we_i    = we;
    cmd_adr_i   = adr;
    cmd_len_i   = len[7:0];
    #1 check_eq("cmd_ready", 32'(cmd_ready_o), 1);
    @(posedge wb_clk_i);
    beat = 0; cyc_n = 0; stall_left = stall;
    exp_rv = 0; exp_done = 0; exp_err = 0; exp_rdat = 0;
    retry_pend = 0; rst_pend = 0; finished = 0; ev_used = 0;
    while (!finished) begin
      @(negedge wb_clk_i);
      cmd_valid_i = 1'b0;
      wbm_ack_i = 1'b0; wbm_err_i = 1'b0; wbm_rty_i = 1'b0;
      wbm_dat_i = $urandom;
      wb_rst_i  = 1'b0;
      cyc_n++;
      if (cyc_n > 3000) begin
        check_eq("timeout", 1, 0);
        finished = 1;
      end else begin
        #1;
        check_eq("rdat_valid", 32'(rdat_valid_o), 32'(exp_rv));
        if (exp_rv) check_eq("rdat", rdat_o, exp_rdat);
        check_eq("done", 32'(done_o), 32'(exp_done));
        check_eq("err", 32'(err_o), 32'(exp_err));
        exp_rv = 0;
        if (rst_pend) begin
          check_reset_values("post_rst");
          finished = 1;
        end else if (exp_done) begin
          check_eq("cmd_ready_done", 32'(cmd_ready_o), 1);
          check_eq("cyc_done", 32'(wbm_cyc_o), 0);
          finished = 1;
        end else if (retry_pend) begin
          check_eq("cyc_retry", 32'(wbm_cyc_o), 0);
          check_eq("stb_retry", 32'(wbm_stb_o), 0);
          retry_pend = 0;
        end else begin
          wdat_valid_i = (stall_left > 0) ? 1'b0 : ($urandom_range(99) < 80);
          if (stall_left > 0) stall_left--;
          wdat_i = wq[beat];
          #1;
          check_eq("cyc", 32'(wbm_cyc_o), 1);
          check_eq("stb", 32'(wbm_stb_o), we ? 32'(wdat_valid_i) : 1);
          if (wbm_stb_o) begin
            ea = adr + 32'(beat * 4);
            check_eq("adr", wbm_adr_o, ea);
            check_eq("cti", 32'(wbm_cti_o), (beat == len) ? 7 : 2);
            check_eq("we", 32'(wbm_we_o), 32'(we));
            check_eq("sel", 32'(wbm_sel_o), 32'hf);
            check_eq("bte", 32'(wbm_bte_o), 0);
            if (we) check_eq("wdat", wbm_dat_o, wq[beat]);
            if (beat == rst_beat) begin
              wb_rst_i = 1'b1;
              rst_pend = 1;
            end else if (beat == err_beat && !ev_used) begin
              wbm_err_i = 1'b1;
              wbm_ack_i = ($urandom_range(1) == 1);
              ev_used = 1; exp_done = 1; exp_err = 1;
            end else if (beat == rty_beat && !ev_used) begin
              wbm_rty_i = 1'b1;
              ev_used = 1;
`ifdef WB_BURST_MASTER_RTY_EN
              retry_pend = 1;
`else
              exp_done = 1; exp_err = 1;
`endif
            end else if ($urandom_range(99) < ackp) begin
              wbm_ack_i = 1'b1;
              if (!we) begin
                exp_rv   = 1;
                exp_rdat = wbm_dat_i;
              end
              beat++;
              if (beat == nbeats) exp_done = 1;
            end
          end
          #1 check_eq("wdat_ready", 32'(wdat_ready_o),
                      32'(we && wbm_ack_i && !wbm_err_i && !wbm_rty_i));
        end
      end
    end
  endtask

  initial begin
    int len, eb, rb, r;
    cmd_valid_i = 0; cmd_we_i = 0; cmd_adr_i = 0; cmd_len_i = 0;
    wdat_i = 0; wdat_valid_i = 0;
    wbm_ack_i = 0; wbm_err_i = 0; wbm_rty_i = 0; wbm_dat_i = 0;
    wb_rst_i = 1'b1;
    repeat (3) @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    #1 check_reset_values("reset");

    run_cmd(1'b0, 32'h0000_0100, 3,   100, 0, -1, -1, -1);
    run_cmd(1'b1, 32'h0000_2000, 1,   100, 3, -1, -1, -1);
    run_cmd(1'b0, 32'hFFFF_FFF0, 255, 100, 0, -1, -1, -1);
    run_cmd(1'b0, 32'h0000_0400, 7,   100, 0,  2, -1, -1);
    run_cmd(1'b1, 32'h0000_0800, 3,   100, 0, -1,  1, -1);
    run_cmd(1'b0, 32'h0000_0C00, 7,   100, 0, -1, -1,  3);
    run_cmd(1'b1, 32'h0000_1000, 5,    70, 0, -1, -1, -1);

    for (int n = 0; n < 30; n++) begin
      len = $urandom_range(15);
      r   = $urandom_range(9);
      eb  = (r == 0) ? $urandom_range(len) : -1;
      rb  = (r == 1) ? $urandom_range(len) : -1;
      run_cmd(1'($urandom_range(1)), $urandom & 32'hFFFF_FFFC, len, 60, 0, eb, rb, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
